// File: rtl/disp_pkg.sv
// Shared pixel type, fallback colour and scheduler state encoding for the
// display source scheduler.
package disp_pkg;

  localparam int PIX_W = 24;

  typedef logic [PIX_W-1:0] rgb_t;

  localparam rgb_t FALLBACK_COLOR = 24'h000000;

  typedef enum logic {
    RUN  = 1'b0,
    EVAL = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first set bit of req
// found when scanning upward from index start, wrapping around.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic          found
);

  // Outer loop walks the distance from start, inner loop finds the index at it.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((i + N - int'(start)) % N) == k)) begin
          onehot[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/disp_src_sched.sv
// Frame-synchronous source scheduler: shares the disp_driver pixel path among
// NUM_SRC sources, switching owner only at vsync. Define DISP_SRC_SCHED_STATS_EN
// to keep the frame_cnt / underflow_cnt statistics counters.
module disp_src_sched
  import disp_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DEFAULT_SRC    = 0,
  parameter int HOLD_FRAMES    = 2,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vs_in,
  input  logic                     de_in,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*PIX_W-1:0] pix_in,
  output logic [NUM_SRC-1:0]       grant,
  output logic [PIX_W-1:0]         pix_out,
  output logic                     switch_pulse,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              underflow_cnt
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = 8;
  localparam logic [CW-1:0] HOLD_MAX   = CW'(HOLD_FRAMES);
  localparam logic [CW-1:0] STRIKE_MAX = CW'(TIMEOUT_FRAMES);
  localparam logic [NUM_SRC-1:0] DEF_OH = NUM_SRC'(1) << DEFAULT_SRC;

  sched_state_t        state_q, state_d;
  logic                vs_q, vs_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [NUM_SRC-1:0]  masked_q, masked_d;
  logic [CW-1:0]       hold_q, hold_d;
  logic [CW-1:0]       strike_q, strike_d;
  logic                frame_uf_q, frame_uf_d;
  rgb_t                pix_q, pix_d;
  logic                pulse_q, pulse_d;

  logic [IW-1:0]       owner_idx, start_idx;
  rgb_t                owner_pix;
  logic                owner_valid, vs_rise, underflow, revoke;
  logic [CW-1:0]       strike_eval;
  logic [NUM_SRC-1:0]  masked_eval, cand, cand_other, next_grant;
  logic [NUM_SRC-1:0]  pick_any_oh, pick_other_oh;
  logic                pick_any_found, pick_other_found;

  always_comb begin
    owner_idx = '0;
    owner_pix = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        owner_idx = IW'(i);
        owner_pix = pix_in[i*PIX_W +: PIX_W];
      end
    end
    owner_valid = |(src_valid & grant_q);
    start_idx   = (owner_idx == IW'(NUM_SRC - 1)) ? '0 : owner_idx + 1'b1;
  end

  // Strike count the EVAL would commit if the owner stays; revocation uses it directly.
  always_comb begin
    vs_rise     = vs_in & ~vs_q;
    underflow   = de_in & ~owner_valid;
    if (!frame_uf_q)
      strike_eval = '0;
    else if (strike_q >= STRIKE_MAX)
      strike_eval = strike_q;
    else
      strike_eval = strike_q + 1'b1;
    revoke      = (strike_eval >= STRIKE_MAX);
    masked_eval = ((masked_q & req) | (revoke ? grant_q : '0)) & ~DEF_OH;
    cand        = req & ~masked_eval;
    cand_other  = cand & ~grant_q;
  end

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick_any (
    .req    (cand),
    .start  (start_idx),
    .onehot (pick_any_oh),
    .found  (pick_any_found)
  );

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick_other (
    .req    (cand_other),
    .start  (start_idx),
    .onehot (pick_other_oh),
    .found  (pick_other_found)
  );

  always_comb begin
    if (revoke || !(|(req & grant_q)))
      next_grant = pick_any_found ? pick_any_oh : DEF_OH;
    else if (pick_other_found && (hold_q >= HOLD_MAX))
      next_grant = pick_other_oh;
    else
      next_grant = grant_q;
  end

  always_comb begin
    state_d    = state_q;
    vs_d       = vs_in;
    grant_d    = grant_q;
    masked_d   = masked_q;
    hold_d     = hold_q;
    strike_d   = strike_q;
    frame_uf_d = frame_uf_q | underflow;
    pulse_d    = 1'b0;
    if (!de_in)
      pix_d = '0;
    else if (underflow)
      pix_d = FALLBACK_COLOR;
    else
      pix_d = owner_pix;

    case (state_q)
      RUN: begin
        if (vs_rise) state_d = EVAL;
      end
      EVAL: begin
        state_d    = RUN;
        masked_d   = masked_eval;
        // An underflow on the EVAL cycle belongs to the frame now starting.
        frame_uf_d = underflow;
        grant_d    = next_grant;
        if (next_grant != grant_q) begin
          pulse_d  = 1'b1;
          hold_d   = CW'(1);
          strike_d = '0;
        end else begin
          hold_d   = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 1'b1;
          strike_d = strike_eval;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      vs_q       <= 1'b0;
      grant_q    <= DEF_OH;
      masked_q   <= '0;
      hold_q     <= '0;
      strike_q   <= '0;
      frame_uf_q <= 1'b0;
      pix_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      grant_q    <= grant_d;
      masked_q   <= masked_d;
      hold_q     <= hold_d;
      strike_q   <= strike_d;
      frame_uf_q <= frame_uf_d;
      pix_q      <= pix_d;
      pulse_q    <= pulse_d;
    end
  end

  assign grant        = grant_q;
  assign pix_out      = pix_q;
  assign switch_pulse = pulse_q;

`ifdef DISP_SRC_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, vs_rise};
    uf_cnt_d    = (underflow && (uf_cnt_q != 16'hFFFF)) ? uf_cnt_q + 16'd1 : uf_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      uf_cnt_q    <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      uf_cnt_q    <= uf_cnt_d;
    end
  end

  assign frame_cnt     = frame_cnt_q;
  assign underflow_cnt = uf_cnt_q;
`else
  assign frame_cnt     = 16'h0000;
  assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_disp_src_sched.sv
// Self-checking bench for disp_src_sched: frame-level reference model of the
// ownership rules, random pixels/valids, and directed hold/watchdog/reset scenarios.
`timescale 1ns/1ps
module tb_disp_src_sched;

  localparam int N    = 4;
  localparam int DEF  = 0;
  localparam int HOLD = 2;
  localparam int TMO  = 4;
  localparam int ACT  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs_in, de_in;
  logic [3:0]  req, src_valid;
  logic [95:0] pix_in;
  logic [3:0]  grant;
  logic [23:0] pix_out;
  logic        switch_pulse;
  logic [15:0] frame_cnt, underflow_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state, advanced once per frame boundary.
  int       m_owner, m_hold, m_strike, m_frame_cnt, m_uf_cnt;
  bit [3:0] m_masked;
  bit       m_frame_uf, m_prev_vs, m_eval_pending, m_changed;
  logic [23:0] exp_q[$];

  disp_src_sched #(
    .NUM_SRC(N), .DEFAULT_SRC(DEF), .HOLD_FRAMES(HOLD), .TIMEOUT_FRAMES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .req(req),
    .src_valid(src_valid), .pix_in(pix_in), .grant(grant), .pix_out(pix_out),
    .switch_pulse(switch_pulse), .frame_cnt(frame_cnt), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = DEF; m_hold = 0; m_strike = 0; m_masked = '0;
    m_frame_uf = 0; m_prev_vs = 0; m_eval_pending = 0; m_changed = 0;
    m_frame_cnt = 0; m_uf_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic void model_eval(input logic [3:0] r);
    int  nxt, j;
    bit  revoked, found;
    m_strike = m_frame_uf ? ((m_strike >= TMO) ? TMO : m_strike + 1) : 0;
    revoked  = (m_strike >= TMO);
    for (int i = 0; i < N; i++) if (!r[i]) m_masked[i] = 1'b0;
    if (revoked && m_owner != DEF) m_masked[m_owner] = 1'b1;
    nxt = m_owner; found = 0;
    if (revoked || !r[m_owner]) begin
      nxt = DEF;
      for (int k = 1; k <= N; k++) begin
        j = (m_owner + k) % N;
        if (!found && r[j] && !m_masked[j]) begin nxt = j; found = 1; end
      end
    end else if (m_hold >= HOLD) begin
      for (int k = 1; k < N; k++) begin
        j = (m_owner + k) % N;
        if (!found && r[j] && !m_masked[j]) begin nxt = j; found = 1; end
      end
    end
    m_changed = (nxt != m_owner);
    if (m_changed) begin
      m_owner = nxt; m_hold = 1; m_strike = 0;
    end else begin
      m_hold = (m_hold + 1 > HOLD) ? HOLD : m_hold + 1;
    end
    m_frame_uf = 0;
  endfunction

  // One clock of stimulus; the model predicts every output seen after the edge.
  task automatic cyc(input logic v, input logic d, input logic [3:0] val, input logic [3:0] r);
    logic [95:0] px;
    logic [23:0] ep;
    logic [3:0]  eg;
    logic [15:0] efc, euc;
    bit do_eval, uf;
    px = {$urandom, $urandom, $urandom};
    vs_in = v; de_in = d; src_valid = val; req = r; pix_in = px;
    do_eval = m_eval_pending;
    m_eval_pending = v && !m_prev_vs;
    m_prev_vs = v;
    uf = d && !val[m_owner];
    ep = 24'h0;
    if (d && !uf) ep = px[m_owner*24 +: 24];
    exp_q.push_back(ep);
    if (m_eval_pending) m_frame_cnt = (m_frame_cnt + 1) % 65536;
    if (uf && m_uf_cnt < 65535) m_uf_cnt++;
    @(posedge clk);
    @(negedge clk);
    m_changed = 0;
    if (do_eval) model_eval(r);
    if (uf) m_frame_uf = 1;
    eg = 4'b0001 << m_owner;
`ifdef DISP_SRC_SCHED_STATS_EN
    efc = 16'(m_frame_cnt); euc = 16'(m_uf_cnt);
`else
    efc = 16'h0; euc = 16'h0;
`endif
    total++;
    if (pix_out !== exp_q[0]) begin bad++; $display("FAIL pix_out: got %h want %h", pix_out, exp_q[0]); end
    void'(exp_q.pop_front());
    total++;
    if (grant !== eg) begin bad++; $display("FAIL grant: got %b want %b", grant, eg); end
    total++;
    if (switch_pulse !== m_changed) begin bad++; $display("FAIL switch_pulse: got %b want %b", switch_pulse, m_changed); end
    total++;
    if (frame_cnt !== efc) begin bad++; $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, efc); end
    total++;
    if (underflow_cnt !== euc) begin bad++; $display("FAIL underflow_cnt: got %0d want %0d", underflow_cnt, euc); end
  endtask

  // vsync burst (EVAL sees er), one quiet cycle, active line with a starve window, blanking.
  task automatic run_frame(input logic [3:0] er, input int uf_n, input int vs_len, input bit de_vs);
    logic [3:0] val;
    int ws;
    for (int i = 0; i < vs_len; i++) cyc(1'b1, de_vs ? 1'($urandom) : 1'b0, 4'($urandom), er);
    cyc(1'b0, 1'b0, 4'($urandom), 4'($urandom));
    ws = $urandom_range(0, ACT - uf_n);
    for (int i = 0; i < ACT; i++) begin
      val = 4'($urandom);
      val[m_owner] = !(i >= ws && i < ws + uf_n);
      cyc(1'b0, 1'b1, val, 4'($urandom));
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'($urandom), 4'($urandom));
  endtask

  task automatic apply_reset();
    rst = 1'b1; vs_in = 1'b0; de_in = 1'($urandom); req = 4'($urandom);
    src_valid = 4'($urandom); pix_in = {$urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL rst_grant: got %b want 0001", grant); end
    total++;
    if (pix_out !== 24'h0) begin bad++; $display("FAIL rst_pix: got %h want 000000", pix_out); end
    total++;
    if (switch_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse: got %b want 0", switch_pulse); end
    total++;
    if (frame_cnt !== 16'h0) begin bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    total++;
    if (underflow_cnt !== 16'h0) begin bad++; $display("FAIL rst_uf_cnt: got %0d want 0", underflow_cnt); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_default_owner();
    run_frame(4'b0000, 0, 2, 1'b0);
    run_frame(4'b0000, 0, 2, 1'b0);
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL default_owner: got %b want 0001", grant); end
  endtask

  task automatic test_mid_frame_req();
    run_frame(4'b0110, 0, 2, 1'b0);
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL first_switch: got %b want 0010", grant); end
  endtask

  task automatic test_hold_rotation();
    logic [3:0]  seq [6];
    logic [15:0] fc0;
    seq = '{4'b0010, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0100};
    for (int f = 0; f < 6; f++) begin
      fc0 = frame_cnt;
      run_frame(4'b0110, 0, 2, 1'b0);
      total++;
      if (grant !== seq[f]) begin bad++; $display("FAIL hold_seq%0d: got %b want %b", f, grant, seq[f]); end
`ifdef DISP_SRC_SCHED_STATS_EN
      total++;
      if (frame_cnt !== fc0 + 16'd1) begin bad++; $display("FAIL frame_step: got %0d want %0d", frame_cnt, fc0 + 16'd1); end
`endif
    end
  endtask

  task automatic test_watchdog();
    logic [15:0] uc0;
    uc0 = underflow_cnt;
    for (int f = 0; f < 4; f++) run_frame(4'b0010, 5, 2, 1'b0);
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL wd_before: got %b want 0010", grant); end
`ifdef DISP_SRC_SCHED_STATS_EN
    total++;
    if (underflow_cnt !== uc0 + 16'd20) begin bad++; $display("FAIL wd_uf20: got %0d want %0d", underflow_cnt, uc0 + 16'd20); end
`endif
    run_frame(4'b0010, 0, 2, 1'b0);
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL wd_revoke: got %b want 0001", grant); end
    run_frame(4'b0010, 0, 2, 1'b0);
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL wd_masked: got %b want 0001", grant); end
    run_frame(4'b0000, 0, 2, 1'b0);
    run_frame(4'b0010, 0, 2, 1'b0);
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL wd_reeligible: got %b want 0010", grant); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fc0;
    fc0 = frame_cnt;
    cyc(1'b1, 1'b0, 4'($urandom), 4'b0100);
    cyc(1'b0, 1'b0, 4'($urandom), 4'b0100);
    cyc(1'b1, 1'b0, 4'($urandom), 4'b1000);
    cyc(1'b1, 1'b0, 4'($urandom), 4'b1000);
    cyc(1'b0, 1'b0, 4'($urandom), 4'b1000);
    total++;
    if (grant !== 4'b1000) begin bad++; $display("FAIL b2b_grant: got %b want 1000", grant); end
`ifdef DISP_SRC_SCHED_STATS_EN
    total++;
    if (frame_cnt !== fc0 + 16'd2) begin bad++; $display("FAIL b2b_frames: got %0d want %0d", frame_cnt, fc0 + 16'd2); end
`endif
    fc0 = frame_cnt;
    run_frame(4'b1000, 0, 12, 1'b0);
    total++;
    if (grant !== 4'b1000) begin bad++; $display("FAIL long_vs_grant: got %b want 1000", grant); end
`ifdef DISP_SRC_SCHED_STATS_EN
    total++;
    if (frame_cnt !== fc0 + 16'd1) begin bad++; $display("FAIL long_vs_frames: got %0d want %0d", frame_cnt, fc0 + 16'd1); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    cyc(1'b0, 1'b1, 4'b1111, 4'($urandom));
    cyc(1'b0, 1'b1, 4'b0111, 4'($urandom));
    apply_reset();
    cyc(1'b0, 1'b1, 4'b0001, 4'($urandom));
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL post_rst_grant: got %b want 0001", grant); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 30; f++)
      run_frame(4'($urandom), $urandom_range(0, 3), $urandom_range(2, 4), 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; vs_in = 1'b0; de_in = 1'b0; req = '0; src_valid = '0; pix_in = '0;
    model_reset();
    test_reset();
    test_default_owner();
    test_mid_frame_req();
    test_hold_rotation();
    test_watchdog();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
